mult_8x8_seq_sched: RTL

//   Time-multiplexes ONE shared 4x4 approximate sub-multiplier (LM-3 class) to form an 8x8 product.

---
 rtl/mult_8x8_seq_sched_if.sv | 36 +++
 rtl/mult_8x8_seq_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_8x8_seq_sched_if.sv
// mult_8x8_seq_sched_if
//   Bundles the operand, result and shared sub-multiplier signals of
//   mult_8x8_seq_sched.
//   slave  : the sequencer side (mult_8x8_seq_sched).
//   master : the environment side (operand source, result sink and the
//            shared 4x4 sub-multiplier).
//   Signals:
//     in_valid/in_ready/in_a/in_b   operand handshake, operands 2*NW bits
//     out_valid/out_ready/out_r     result handshake, product 4*NW bits
//     mul_en/mul_a/mul_b            issue strobe and nibbles to sub-multiplier
//     mul_r                         sub-multiplier product, 2*NW bits
interface mult_8x8_seq_sched_if #(
    parameter int NW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [2*NW-1:0]   in_a;
    logic [2*NW-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [4*NW-1:0]   out_r;
    logic              mul_en;
    logic [NW-1:0]     mul_a;
    logic [NW-1:0]     mul_b;
    logic [2*NW-1:0]   mul_r;

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_r,
        input  in_ready, out_valid, out_r, mul_en, mul_a, mul_b
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_r,
        output in_ready, out_valid, out_r, mul_en, mul_a, mul_b
    );
endinterface

// File: rtl/mult_8x8_seq_sched.sv
// mult_8x8_seq_sched
//   Forms a (2*NW)x(2*NW) product with ONE shared NWxNW sub-multiplier.
//   The four nibble partial products are issued one per cycle in the fixed
//   order AL*BL, AL*BH, AH*BL, AH*BH and shift-accumulated into a 4*NW-bit
//   result that is presented on a valid/ready output.
//   Parameters:
//     NW       nibble width (operands 2*NW, result 4*NW)
//     MUL_LAT  sub-multiplier latency in cycles, 0 = combinational (0..3)
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     bus      mult_8x8_seq_sched_if.slave: operand handshake (in_*),
//              result handshake (out_*), sub-multiplier issue (mul_en,
//              mul_a, mul_b) and its product return (mul_r)
//   Build option:
//     ZERO_SKIP_EN  when defined, partial products whose A or B nibble is
//                   zero are not issued; the remaining ones stay in order.
module mult_8x8_seq_sched #(
    parameter int NW      = 4,
    parameter int MUL_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_8x8_seq_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [2*NW-1:0]   a_q;
    logic [2*NW-1:0]   b_q;
    logic [3:0]        pend_q;      // bit k set: partial product k still to issue
    logic [4*NW-1:0]   acc;
    logic [NW-1:0]     mul_a_q;
    logic [NW-1:0]     mul_b_q;

    logic              hs;
    logic [3:0]        start_mask;
    logic [1:0]        k_sel;
    logic [3:0]        pend_clr;
    logic              issue;
    logic [NW-1:0]     sel_a;
    logic [NW-1:0]     sel_b;

    logic              cap_v;
    logic [1:0]        cap_k;
    logic              drain_busy;
    logic [4*NW-1:0]   prod_ext;
    logic [4*NW-1:0]   addend;

    assign hs = bus.in_ready & bus.in_valid;

    // Which partial products a new job needs.
`ifdef ZERO_SKIP_EN
    always_comb begin
        start_mask[0] = (bus.in_a[NW-1:0]    != '0) && (bus.in_b[NW-1:0]    != '0);
        start_mask[1] = (bus.in_a[NW-1:0]    != '0) && (bus.in_b[2*NW-1:NW] != '0);
        start_mask[2] = (bus.in_a[2*NW-1:NW] != '0) && (bus.in_b[NW-1:0]    != '0);
        start_mask[3] = (bus.in_a[2*NW-1:NW] != '0) && (bus.in_b[2*NW-1:NW] != '0);
    end
`else
    assign start_mask = '1;
`endif

    // Lowest pending index is issued next; this keeps the fixed k order
    // and packs surviving products back-to-back when some are skipped.
    always_comb begin
        k_sel = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (pend_q[i-1]) k_sel = 2'(i - 1);
        end
    end

    assign issue    = (state == ISSUE) && (pend_q != '0);
    assign pend_clr = pend_q & ~(4'b0001 << k_sel);
    // k bit 1 selects the A high nibble, k bit 0 selects the B high nibble.
    assign sel_a    = k_sel[1] ? a_q[2*NW-1:NW] : a_q[NW-1:0];
    assign sel_b    = k_sel[0] ? b_q[2*NW-1:NW] : b_q[NW-1:0];

    // Shift tag travels with the issue strobe so capture lines up with mul_r.
    generate
        if (MUL_LAT == 0) begin : g_comb
            assign cap_v      = issue;
            assign cap_k      = k_sel;
            assign drain_busy = 1'b0;
        end else begin : g_pipe
            logic [MUL_LAT-1:0] pv;
            logic [1:0]         pk [MUL_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                    for (int unsigned i = 0; i < MUL_LAT; i++) pk[i] <= '0;
                end else begin
                    pv[0] <= issue;
                    pk[0] <= k_sel;
                    for (int unsigned i = 1; i < MUL_LAT; i++) begin
                        pv[i] <= pv[i-1];
                        pk[i] <= pk[i-1];
                    end
                end
            end

            assign cap_v = pv[MUL_LAT-1];
            assign cap_k = pk[MUL_LAT-1];
            // Done draining once only the final stage (captured this cycle)
            // may still hold a product.
            assign drain_busy = (pv & ~(MUL_LAT'(1) << (MUL_LAT - 1))) != '0;
        end
    endgenerate

    assign prod_ext = {{(2*NW){1'b0}}, bus.mul_r};

    always_comb begin
        case (cap_k)
            2'd0:    addend = prod_ext;
            2'd3:    addend = prod_ext << (2*NW);
            default: addend = prod_ext << NW;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (hs) state_nx = ISSUE;
            end
            ISSUE: begin
                if (pend_q == '0)
                    state_nx = DONE;
                else if (pend_clr == '0)
                    state_nx = (MUL_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (!drain_busy) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs. in_ready is held low while reset is asserted.
    always_comb begin
        bus.in_ready  = (state == IDLE) && rst_n;
        bus.out_valid = (state == DONE);
        bus.out_r     = acc;
        bus.mul_en    = issue;
        bus.mul_a     = issue ? sel_a : mul_a_q;
        bus.mul_b     = issue ? sel_b : mul_b_q;
    end

    // Datapath: operand capture, pending mask, nibble hold and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            pend_q  <= '0;
            acc     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (hs) begin
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            pend_q <= start_mask;
            acc    <= '0;
        end else begin
            if (issue) begin
                pend_q  <= pend_clr;
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end
            if (cap_v) acc <= acc + addend;
        end
    end

endmodule
